// File: rtl/io_out_buffer.sv
// Output byte FIFO between the CPU memory bus and the UART transmitter.
// Snoops I/O writes, handles the program-stop write and keeps the cycle counter.
module io_out_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop,
  output logic        overflow_err,
  output logic [31:0] cycle_cnt
);

  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_d;
  logic [1:0]    state_q, state_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycle_q, cycle_d;

  logic          io_wr;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;
  logic [7:0]    push_byte;
  logic          unused_addr;

  assign unused_addr = ^{mem_a[31:18], mem_a[15:3], mem_a[1:0]};

  // Writes are only honoured while running; DRAIN and STOPPED ignore the bus.
  assign io_wr     = rdy_in && mem_wr && (mem_a[17:16] == 2'b11) && (state_q == ST_RUN);
  assign push_req  = io_wr && (mem_a[2] || (mem_dout != 8'h00));
  assign push_byte = mem_a[2] ? 8'h00 : mem_dout;

  assign tx_valid = (count_q != '0);
  assign pop      = tx_valid && tx_ready;
  assign push     = push_req && ((count_q != DEPTH_C) || pop);
  assign drop     = push_req && (count_q == DEPTH_C) && !pop;

  assign tx_data        = tx_valid ? mem_q[rptr_q] : 8'h00;
  assign io_buffer_full = full_q;
  assign overflow_err   = ovf_q;
  assign prog_stop      = (state_q == ST_STOP);
  assign cycle_cnt      = cycle_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    state_d = state_q;
    ovf_d   = ovf_q || drop;
    cycle_d = cycle_q;

    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // The stop byte is always the last entry, so an empty FIFO in DRAIN means it is gone.
    if ((state_q == ST_RUN) && io_wr && mem_a[2]) begin
      state_d = ST_DRAIN;
    end else if ((state_q == ST_DRAIN) && (count_q == '0)) begin
      state_d = ST_STOP;
    end

    if (rdy_in && (state_q != ST_STOP)) begin
      cycle_d = cycle_q + 32'd1;
    end

    free_d = DEPTH_C - count_d;
    full_d = (state_d != ST_RUN) || (free_d <= MARGIN_C);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= ST_RUN;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cycle_q <= 32'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  // Storage needs no reset: tx_data is masked to zero while the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wptr_q] <= push_byte;
    end
  end

endmodule

// File: tb/tb_io_out_buffer.sv
// Randomized scoreboard bench for io_out_buffer: a queue-based reference model
// predicts every byte and flag, a negedge monitor checks the transmit stream.
module tb_io_out_buffer;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
  localparam int M_RUN     = 0;
  localparam int M_DRAIN   = 1;
  localparam int M_STOPPED = 2;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prog_stop;
  logic        overflow_err;
  logic [31:0] cycle_cnt;

  io_out_buffer #(.DEPTH_LOG2(4), .FULL_MARGIN(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .prog_stop      (prog_stop),
    .overflow_err   (overflow_err),
    .cycle_cnt      (cycle_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic [7:0]  expQ[$];
  int          pushedNow;
  int          mMode;
  logic        expFull;
  logic        expOvf;
  logic        expStop;
  logic [31:0] expCycles;
  int          nCompared;
  int          nMismatched;
  bit          started;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("io_buffer_full", 32'(io_buffer_full), 32'(expFull));
    checkVal("overflow_err", 32'(overflow_err), 32'(expOvf));
    checkVal("prog_stop", 32'(prog_stop), 32'(expStop));
    checkVal("cycle_cnt", cycle_cnt, expCycles);
  endtask

  // Reference model: decides what the coming clock edge does to the byte queue and flags.
  task automatic predictEdge();
    int cnt;
    int cntNext;
    int nextMode;
    bit popNow;
    bit pushed;
    cnt      = expQ.size();
    popNow   = (cnt > 0) && tx_ready;
    pushed   = 1'b0;
    nextMode = mMode;
    if (mMode == M_DRAIN && cnt == 0) nextMode = M_STOPPED;
    if (rdy_in && mem_wr && mem_a[17:16] == 2'b11 && mMode == M_RUN) begin
      if (mem_a[2]) nextMode = M_DRAIN;
      if (mem_a[2] || mem_dout != 8'h00) begin
        if (cnt < DEPTH || popNow) begin
          expQ.push_back(mem_a[2] ? 8'h00 : mem_dout);
          pushed = 1'b1;
        end else begin
          expOvf = 1'b1;
        end
      end
    end
    if (rdy_in && mMode != M_STOPPED) expCycles = expCycles + 32'd1;
    mMode     = nextMode;
    pushedNow = pushed ? 1 : 0;
    cntNext   = cnt + (pushed ? 1 : 0) - (popNow ? 1 : 0);
    expFull   = (mMode != M_RUN) || ((DEPTH - cntNext) <= MARGIN);
    expStop   = (mMode == M_STOPPED);
  endtask

  task automatic applyStimulus(input logic rdy, input logic wr, input logic [31:0] addr,
                               input logic [7:0] dout, input logic txr);
    @(posedge clk_in);
    #1;
    checkOutput();
    rdy_in   = rdy;
    mem_wr   = wr;
    mem_a    = addr;
    mem_dout = dout;
    tx_ready = txr;
    predictEdge();
  endtask

  task automatic idle(input int n, input logic rdy, input logic txr);
    for (int i = 0; i < n; i++) applyStimulus(rdy, 1'b0, 32'h0, 8'h00, txr);
  endtask

  // Reset is raised off-edge so its effect on the outputs must be immediate.
  task automatic doReset();
    #2;
    rst_in   = 1'b1;
    rdy_in   = 1'b0;
    mem_wr   = 1'b0;
    mem_a    = 32'h0;
    mem_dout = 8'h00;
    tx_ready = 1'b0;
    #1;
    checkVal("reset tx_valid", 32'(tx_valid), 32'd0);
    checkVal("reset tx_data", 32'(tx_data), 32'd0);
    checkVal("reset io_buffer_full", 32'(io_buffer_full), 32'd0);
    checkVal("reset prog_stop", 32'(prog_stop), 32'd0);
    checkVal("reset overflow_err", 32'(overflow_err), 32'd0);
    checkVal("reset cycle_cnt", cycle_cnt, 32'd0);
    expQ.delete();
    pushedNow = 0;
    mMode     = M_RUN;
    expFull   = 1'b0;
    expOvf    = 1'b0;
    expStop   = 1'b0;
    expCycles = 32'd0;
    repeat (2) @(posedge clk_in);
    #3;
    rst_in = 1'b0;
  endtask

  // Monitor: mid-cycle, pops the scoreboard whenever the model says a byte leaves.
  always @(negedge clk_in) begin
    if (started && !rst_in) begin
      logic expValid;
      expValid = (expQ.size() - pushedNow) > 0;
      checkVal("tx_valid", 32'(tx_valid), 32'(expValid));
      if (expValid && tx_ready) begin
        checkVal("tx_data", 32'(tx_data), 32'(expQ.pop_front()));
      end
      pushedNow = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [7:0]  data;
    nCompared   = 0;
    nMismatched = 0;
    started     = 1'b0;
    rst_in      = 1'b0;
    doReset();
    started = 1'b1;

    applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h41, 1'b1);
    idle(3, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h00, 1'b1);
    idle(2, 1'b1, 1'b1);

    // Fill past capacity with the transmitter stalled, then push while full and popping.
    for (int i = 0; i < 17; i++) begin
      addr = 32'h0003_0000 | (32'($urandom_range(0, 3)) & 32'h3) | 32'h8;
      data = 8'($urandom_range(1, 255));
      applyStimulus(1'b1, 1'b1, addr, data, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h55, 1'b1);
    idle(20, 1'b1, 1'b1);

    for (int i = 0; i < 400; i++) begin
      addr        = $urandom;
      addr[17:16] = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b11;
      addr[2]     = 1'b0;
      data        = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), addr, data,
                    ($urandom_range(0, 2) != 0));
    end
    idle(20, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h48, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h69, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0003_0004, 8'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h5A, 1'b1);
    idle(10, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);

    doReset();
    applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h42, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 32'h0003_0000, 8'h77, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'($urandom_range(1, 255)), 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1);
    doReset();
    idle(3, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/io_out_buffer.md
# io_out_buffer

Byte FIFO between the CPU memory bus and the UART transmitter. It snoops CPU writes to the memory-mapped I/O window and queues output bytes. It drives `io_buffer_full` back to the CPU and handles the program-stop write. It also keeps the cycle counter that the I/O read path returns for address 0x30004.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when free entries ≤ FULL_MARGIN. Must be ≥1 and < 2^DEPTH_LOG2.

Ports:
- `clk_in` in 1: system clock; the single clock of the block.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: CPU ready. Low freezes capture and the cycle counter, but not draining.
- `mem_a` in 32: CPU address bus.
- `mem_wr` in 1: CPU write strobe (1 = write).
- `mem_dout` in 8: CPU write data byte.
- `io_buffer_full` out 1: back-pressure to the CPU.
- `tx_data` out 8: byte at the FIFO head.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: UART accepts `tx_data` this cycle.
- `prog_stop` out 1: level; program has stopped and its terminating 0x00 has been sent.
- `overflow_err` out 1: sticky; a byte was dropped because the FIFO was full.
- `cycle_cnt` out 32: cycles with `rdy_in` high since reset, frozen once stopped.

## Operation
- I/O write (`io_wr`) = `rdy_in && mem_wr && mem_a[17:16]==2'b11`. Only `mem_a[2]` distinguishes targets; other low bits are ignored.
- `mem_a[2]==0` (0x30000), output byte:
  - Push `mem_dout` if it is non-zero.
  - A 0x00 byte is ignored: no push, no flag.
- `mem_a[2]==1` (0x30004), stop:
  - Push 0x00 regardless of `mem_dout` and enter DRAIN.
- FIFO:
  - Circular buffer, `wptr`/`rptr` of DEPTH_LOG2 bits plus `count` of DEPTH_LOG2+1 bits.
  - Pointers wrap modulo depth.
- Pop when `tx_valid && tx_ready`. `tx_data` = `mem[rptr]`, combinational from storage.
- Push when full (`count`==depth) and no same-cycle pop: drop the byte, set `overflow_err`. Nothing else changes.
- Simultaneous push and pop:
  - Both take effect and `count` is unchanged.
  - This applies when full: the pop frees a slot and the push is accepted.
- Push into an empty FIFO: the byte appears on `tx_data`/`tx_valid` the next cycle, never the same cycle.
- State machine:
  - RUN → DRAIN on a stop write. If the stop push is dropped on overflow, still go to DRAIN; `overflow_err` is set.
  - DRAIN: further I/O writes are ignored. Go to STOPPED when `count` reaches 0 after the stop byte was popped or dropped.
  - STOPPED is terminal until reset. `prog_stop`=1, writes are ignored, `cycle_cnt` is frozen.
- `io_buffer_full` = (depth − `count`) ≤ FULL_MARGIN, registered from next-state `count`. It is forced to 1 in DRAIN and STOPPED.
- `cycle_cnt` increments by 1 each cycle with `rdy_in`=1 in RUN or DRAIN. It wraps modulo 2^32.
- Non-I/O writes (`mem_a[17:16]`≠2'b11) and all reads are ignored.

## Timing
- Reset (async, immediate) forces:
  - FIFO empty, state RUN.
  - `tx_valid`=0, `tx_data`=0x00, `io_buffer_full`=0, `prog_stop`=0, `overflow_err`=0, `cycle_cnt`=0.
- Reset mid-drain discards all queued bytes.
- Write capture is on the rising edge where `io_wr`=1. Minimum push-to-`tx_valid` latency is 1 cycle.
- Throughput is one push and one pop per cycle.
- `io_buffer_full` updates on the same edge as the push/pop that changes `count`. The CPU observes it one cycle after the push.
- While `rdy_in`=0:
  - No capture and no count increment.
  - Pops continue when `tx_ready`=1.
- `prog_stop` rises on the edge after the final pop that empties the FIFO in DRAIN.

## Test plan
- Reset, then write 'A' (0x41) to 0x30000 with `tx_ready`=1 → `tx_valid`=1 / `tx_data`=0x41 the next cycle, popped that cycle, `tx_valid`=0 after.
- Write 0x00 to 0x30000 → no push, `tx_valid` stays 0, `overflow_err` stays 0.
- DEPTH_LOG2=4, FULL_MARGIN=2, `tx_ready`=0, 14 writes → `io_buffer_full`=1 after the 14th.
  - 16 writes fill the FIFO; the 17th is dropped and `overflow_err`=1.
  - Then `tx_ready`=1 → bytes emerge in order, pointers wrap correctly.
- FIFO full, same-cycle push 0x55 and pop → `count` stays 16 and 0x55 is emitted last.
- Write 'H','i', then stop write to 0x30004 → `tx_data` sequence 0x48, 0x69, 0x00.
  - `io_buffer_full`=1 from the stop onward; a later 0x30000 write is ignored.
  - `prog_stop`=1 one cycle after the 0x00 pops; `cycle_cnt` frozen from then.
- `rdy_in` low for 5 cycles with a queued byte and `tx_ready`=1 → byte still drains.
  - `cycle_cnt` does not advance; a write strobe during this window is not captured.
  - Assert `rst_in` mid-drain → all outputs return to reset values immediately.
